// File: rtl/adc_spi_slave_if.sv
// adc_spi_slave_if
// SPI pin bundle between an SPI master and the ADC SPI slave.
//   cs      : chip select, active-low, driven by the master
//   sclk    : serial clock, idle low, driven by the master
//   mosi    : command data from the master
//   miso    : sample data to the master, MSB first
//   miso_oe : miso drive enable from the slave (pad is high-Z when 0)
interface adc_spi_slave_if;
    logic cs;
    logic sclk;
    logic mosi;
    logic miso;
    logic miso_oe;

    modport master (output cs, sclk, mosi, input miso, miso_oe);
    modport slave  (input cs, sclk, mosi, output miso, miso_oe);
endinterface

// File: rtl/adc_spi_slave.sv
// adc_spi_slave
// SPI mode-0 slave that streams parallel ADC sample words out on miso and,
// optionally, captures a command word from mosi. The SPI pins are sampled
// into the clk domain through 2-flop synchronisers, so each sclk phase must
// last at least 4 clk periods.
//
// Ports:
//   clk, rst_n  : system clock, asynchronous active-low reset
//   spi         : SPI pins (adc_spi_slave_if.slave)
//   din/din_vld : sample word handshake into the holding register
//   din_rdy     : holding register is empty
//   cmd/cmd_vld : last complete command word and its one-cycle update pulse
//   busy        : a frame is in progress
//   underrun    : pulse when a frame starts with nothing loaded
//   abort       : pulse when cs rises before DW sclk rising edges
//
// Build option: define ADC_SLV_CMD_EN to include mosi capture, cmd and
// cmd_vld. Without it cmd and cmd_vld are tied to 0 and mosi is ignored.
module adc_spi_slave #(
    parameter int DW = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    adc_spi_slave_if.slave spi,
    input  logic [DW-1:0]  din,
    input  logic           din_vld,
    output logic           din_rdy,
    output logic [DW-1:0]  cmd,
    output logic           cmd_vld,
    output logic           busy,
    output logic           underrun,
    output logic           abort
);
    localparam int CW = $clog2(DW) + 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(DW - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DW);

    typedef enum logic [1:0] {WAIT_HI, IDLE, SHIFT, TAIL} state_t;

    state_t        state, state_nxt;
    logic [2:0]    cs_sr, sclk_sr;
    logic          cs_s, cs_fall, cs_rise, sclk_rise, sclk_fall;
    logic [1:0]    warm;
    logic [DW-1:0] hold_data, shift_q;
    logic          hold_full, accept;
    logic [CW-1:0] bit_cnt;
    logic          at_last, shift_act, rise_act;
    logic          frame_start, miso_c, oe_c, busy_c;

    // Bits [1:0] are the synchroniser; bit 2 is the previous synchronised
    // value used for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_sr   <= 3'b111;
            sclk_sr <= 3'b000;
        end else begin
            cs_sr   <= {cs_sr[1:0], spi.cs};
            sclk_sr <= {sclk_sr[1:0], spi.sclk};
        end
    end

    assign cs_s      = cs_sr[1];
    assign cs_fall   =  cs_sr[2]   & ~cs_sr[1];
    assign cs_rise   = ~cs_sr[2]   &  cs_sr[1];
    assign sclk_rise = ~sclk_sr[2] &  sclk_sr[1];
    assign sclk_fall =  sclk_sr[2] & ~sclk_sr[1];

    // The cs synchroniser resets to "high", so for the first few cycles after
    // reset it does not reflect the real pin. WAIT_HI only trusts cs_s once
    // the real pin level has had time to reach it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            warm <= 2'd0;
        else if (warm != 2'd3)
            warm <= warm + 2'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= WAIT_HI;
        else
            state <= state_nxt;
    end

    assign at_last   = (bit_cnt == LAST_BIT);
    assign shift_act = (state == SHIFT) && !cs_rise;
    assign rise_act  = shift_act && sclk_rise;

    always_comb begin
        state_nxt   = state;
        frame_start = 1'b0;
        miso_c      = 1'b0;
        oe_c        = 1'b0;
        busy_c      = 1'b0;
        case (state)
            WAIT_HI: begin
                if (warm == 2'd3 && cs_s)
                    state_nxt = IDLE;
            end
            IDLE: begin
                if (cs_fall) begin
                    state_nxt   = SHIFT;
                    frame_start = 1'b1;
                end
            end
            SHIFT: begin
                busy_c = 1'b1;
                oe_c   = 1'b1;
                miso_c = shift_q[DW-1];
                if (cs_rise)
                    state_nxt = IDLE;
                else if (sclk_rise && at_last)
                    state_nxt = TAIL;
            end
            TAIL: begin
                busy_c = 1'b1;
                oe_c   = 1'b1;
                if (cs_rise)
                    state_nxt = IDLE;
            end
            default: state_nxt = WAIT_HI;
        endcase
    end

    assign accept = din_vld && !hold_full;

    // A word accepted in the frame-start cycle is for the next frame: the
    // current frame copies the old content, which was empty (zeros).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_data <= '0;
            hold_full <= 1'b0;
            shift_q   <= '0;
            bit_cnt   <= '0;
            underrun  <= 1'b0;
            abort     <= 1'b0;
        end else begin
            if (accept) begin
                hold_data <= din;
                hold_full <= 1'b1;
            end else if (frame_start) begin
                hold_full <= 1'b0;
            end

            if (frame_start)
                shift_q <= hold_full ? hold_data : '0;
            else if (shift_act && sclk_fall)
                shift_q <= {shift_q[DW-2:0], 1'b0};

            if (frame_start)
                bit_cnt <= '0;
            else if (rise_act && bit_cnt != FULL_CNT)
                bit_cnt <= bit_cnt + CW'(1);

            underrun <= frame_start && !hold_full;
            abort    <= (state == SHIFT) && cs_rise;
        end
    end

`ifdef ADC_SLV_CMD_EN
    logic [1:0]    mosi_sr;
    logic [DW-1:0] cmd_sr;
    logic          cmd_load;

    // mosi shares the sclk synchroniser depth, so it is sampled in step with
    // the detected rising edge. cmd is published one cycle after the last bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mosi_sr  <= 2'b00;
            cmd_sr   <= '0;
            cmd_load <= 1'b0;
            cmd      <= '0;
            cmd_vld  <= 1'b0;
        end else begin
            mosi_sr <= {mosi_sr[0], spi.mosi};
            if (frame_start)
                cmd_sr <= '0;
            else if (rise_act)
                cmd_sr <= {cmd_sr[DW-2:0], mosi_sr[1]};
            cmd_load <= rise_act && at_last;
            cmd_vld  <= cmd_load;
            if (cmd_load)
                cmd <= cmd_sr;
        end
    end
`else
    assign cmd     = '0;
    assign cmd_vld = 1'b0;
`endif

    assign din_rdy     = !hold_full;
    assign busy        = busy_c;
    assign spi.miso    = miso_c;
    assign spi.miso_oe = oe_c;
endmodule

// File: tb/tb_adc_spi_slave.sv
// tb_adc_spi_slave
// Self-checking bench for adc_spi_slave: a table of whole SPI frames plus
// hand-written sequences for reset mid-frame and a load coinciding with the
// frame start. Expected cmd values depend on ADC_SLV_CMD_EN.
module tb_adc_spi_slave;
    localparam int DW = 16;
`ifdef ADC_SLV_CMD_EN
    localparam bit CMD_EN = 1'b1;
`else
    localparam bit CMD_EN = 1'b0;
`endif

    logic          clk;
    logic          rst_n;
    logic [DW-1:0] din;
    logic          din_vld;
    logic          din_rdy;
    logic [DW-1:0] cmd;
    logic          cmd_vld;
    logic          busy;
    logic          underrun;
    logic          abort;

    adc_spi_slave_if spi_bus();

    adc_spi_slave #(.DW(DW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .spi      (spi_bus),
        .din      (din),
        .din_vld  (din_vld),
        .din_rdy  (din_rdy),
        .cmd      (cmd),
        .cmd_vld  (cmd_vld),
        .busy     (busy),
        .underrun (underrun),
        .abort    (abort)
    );

    int total = 0;
    int bad   = 0;
    int und_tot  = 0;
    int abt_tot  = 0;
    int cv_tot   = 0;
    int busy_tot = 0;
    int oe_tot   = 0;

    // Field order: load, data, mosi_word, nbits, exp_rd, exp_und, exp_abt,
    // exp_cv, exp_cmd
    typedef struct {
        logic        load;
        logic [15:0] data;
        logic [15:0] mosi_word;
        int          nbits;
        logic [31:0] exp_rd;
        int          exp_und;
        int          exp_abt;
        int          exp_cv;
        logic [15:0] exp_cmd;
    } vec_t;

    vec_t vecs[5];
    vec_t post_rst;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse and level monitor; counts cycles each output was high.
    always @(negedge clk) begin
        if (underrun)        und_tot++;
        if (abort)           abt_tot++;
        if (cmd_vld)         cv_tot++;
        if (busy)            busy_tot++;
        if (spi_bus.miso_oe) oe_tot++;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout want test completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] got,
                               input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "_miso"},     spi_bus.miso,    0);
        checkOutput({tag, "_miso_oe"},  spi_bus.miso_oe, 0);
        checkOutput({tag, "_din_rdy"},  din_rdy,         1);
        checkOutput({tag, "_cmd"},      cmd,             0);
        checkOutput({tag, "_cmd_vld"},  cmd_vld,         0);
        checkOutput({tag, "_busy"},     busy,            0);
        checkOutput({tag, "_underrun"}, underrun,        0);
        checkOutput({tag, "_abort"},    abort,           0);
    endtask

    task automatic loadWord(input logic [15:0] w);
        int n = 0;
        @(negedge clk);
        while (!din_rdy && n < 50) begin
            @(negedge clk);
            n++;
        end
        checkOutput("load_wait_rdy", din_rdy, 1);
        din     = w;
        din_vld = 1'b1;
        @(negedge clk);
        din_vld = 1'b0;
    endtask

    // Drops cs; optionally offers a word right in the cs-fall detection cycle
    // and holds it until the handshake completes.
    task automatic startFrame(input bit late_en, input logic [15:0] late_word,
                              input logic first_mosi);
        int n = 0;
        @(negedge clk);
        spi_bus.cs   = 1'b0;
        spi_bus.mosi = first_mosi;
        @(posedge clk);
        @(posedge clk);
        #1;
        if (late_en) begin
            din     = late_word;
            din_vld = 1'b1;
            while (!din_rdy && n < 20) begin
                @(negedge clk);
                n++;
            end
            checkOutput("late_rdy", din_rdy, 1);
            @(posedge clk);
            #1;
            din_vld = 1'b0;
        end
        repeat (6) @(negedge clk);
    endtask

    // Mode-0 master: sample miso as sclk rises, change mosi after sclk falls.
    task automatic clockBits(input int n, input logic [15:0] mw,
                             output logic [31:0] rd);
        int idx;
        rd = '0;
        for (int i = 0; i < n; i++) begin
            spi_bus.sclk = 1'b1;
            rd = {rd[30:0], spi_bus.miso};
            repeat (6) @(negedge clk);
            spi_bus.sclk = 1'b0;
            idx = 14 - i;
            if (idx >= 0)
                spi_bus.mosi = mw[idx];
            else
                spi_bus.mosi = 1'b1;
            repeat (6) @(negedge clk);
        end
    endtask

    task automatic endFrame();
        spi_bus.cs = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic applyStimulus(input vec_t v, input string tag);
        logic [31:0] rd;
        int u0, a0, c0;
        if (v.load) loadWord(v.data);
        checkOutput({tag, "_oe_idle"}, spi_bus.miso_oe, 0);
        u0 = und_tot;
        a0 = abt_tot;
        c0 = cv_tot;
        startFrame(1'b0, 16'h0000, v.mosi_word[15]);
        checkOutput({tag, "_oe_during"},   spi_bus.miso_oe, 1);
        checkOutput({tag, "_busy_during"}, busy,            1);
        clockBits(v.nbits, v.mosi_word, rd);
        endFrame();
        checkOutput({tag, "_read"},     rd,           v.exp_rd);
        checkOutput({tag, "_underrun"}, und_tot - u0, v.exp_und);
        checkOutput({tag, "_abort"},    abt_tot - a0, v.exp_abt);
        checkOutput({tag, "_cmd_vld"},  cv_tot - c0,  CMD_EN ? v.exp_cv : 0);
        checkOutput({tag, "_cmd"},      cmd,          CMD_EN ? v.exp_cmd : 16'h0000);
        checkOutput({tag, "_oe_after"},   spi_bus.miso_oe, 0);
        checkOutput({tag, "_miso_after"}, spi_bus.miso,    0);
        checkOutput({tag, "_busy_after"}, busy,            0);
        checkOutput({tag, "_rdy_after"},  din_rdy,         1);
    endtask

    initial begin
        logic [31:0] rd;
        int u0, a0, c0, b0, o0;

        vecs[0] = '{1'b1, 16'hBFFF, 16'h1234, 16, 32'h0000BFFF, 0, 0, 1, 16'h1234};
        vecs[1] = '{1'b0, 16'h0000, 16'hABCD, 16, 32'h00000000, 1, 0, 1, 16'hABCD};
        vecs[2] = '{1'b1, 16'h1357, 16'hFFFF, 7,  32'h00000009, 0, 1, 0, 16'hABCD};
        vecs[3] = '{1'b1, 16'hA55A, 16'h5AA5, 16, 32'h0000A55A, 0, 0, 1, 16'h5AA5};
        vecs[4] = '{1'b1, 16'hFFFF, 16'h0F0F, 20, 32'h000FFFF0, 0, 0, 1, 16'h0F0F};
        post_rst = '{1'b1, 16'hC3C3, 16'h8001, 16, 32'h0000C3C3, 0, 0, 1, 16'h8001};

        rst_n        = 1'b0;
        din          = '0;
        din_vld      = 1'b0;
        spi_bus.cs   = 1'b1;
        spi_bus.sclk = 1'b0;
        spi_bus.mosi = 1'b0;
        repeat (3) @(negedge clk);
        checkReset("por");
        rst_n = 1'b1;
        repeat (10) @(negedge clk);

        for (int i = 0; i < 5; i++)
            applyStimulus(vecs[i], $sformatf("row%0d", i));

        // Reset with cs held low part-way through a frame.
        loadWord(16'h1234);
        startFrame(1'b0, 16'h0000, 1'b1);
        clockBits(5, 16'hFFFF, rd);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checkReset("midrst");
        rst_n = 1'b1;
        b0 = busy_tot;
        c0 = cv_tot;
        o0 = oe_tot;
        a0 = abt_tot;
        u0 = und_tot;
        clockBits(11, 16'hA5A5, rd);
        checkOutput("midrst_busy_cycles", busy_tot - b0, 0);
        checkOutput("midrst_oe_cycles",   oe_tot - o0,   0);
        checkOutput("midrst_cmd_vld",     cv_tot - c0,   0);
        checkOutput("midrst_underrun",    und_tot - u0,  0);
        endFrame();
        checkOutput("midrst_abort",       abt_tot - a0,  0);
        checkOutput("midrst_busy_end",    busy,          0);
        applyStimulus(post_rst, "postrst");

        // Word offered in the frame-start cycle goes to the next frame.
        loadWord(16'hF0F0);
        u0 = und_tot;
        startFrame(1'b1, 16'h0F0F, 1'b0);
        clockBits(16, 16'h0000, rd);
        endFrame();
        checkOutput("overlap_f1_read",     rd,           32'h0000F0F0);
        checkOutput("overlap_f1_underrun", und_tot - u0, 0);
        checkOutput("overlap_f1_rdy",      din_rdy,      0);
        u0 = und_tot;
        startFrame(1'b0, 16'h0000, 1'b0);
        clockBits(16, 16'h0000, rd);
        endFrame();
        checkOutput("overlap_f2_read",     rd,           32'h00000F0F);
        checkOutput("overlap_f2_underrun", und_tot - u0, 0);
        checkOutput("overlap_f2_rdy",      din_rdy,      1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
